// File: rtl/hazard_pkg.sv
// Shared encodings and defaults for the pipeline hazard unit.
// Sequencer present only when HAZARD_MULDIV_EN is defined.
package hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    localparam logic [1:0] RES_LOAD = 2'b01;

    localparam int MUL_LAT_DEF = 3;
    localparam int DIV_LAT_DEF = 33;
    localparam int CNT_W       = 6;

    typedef enum logic {
        SEQ_IDLE = 1'b0,
        SEQ_BUSY = 1'b1
    } seq_state_e;

    // Memory stage wins over writeback; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_d,
        input logic       we_d,
        input logic [4:0] rd_e,
        input logic       we_e
    );
        if (we_d && rd_d != 5'd0 && rd_d == rs)
            return FWD_MEM;
        else if (we_e && rd_e != 5'd0 && rd_e == rs)
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard unit signal bundle between pipeline and hazard control.
// Optional sequencer build macro: HAZARD_MULDIV_EN.
interface hazard_ctrl_if;

    logic [4:0] Rs1B;
    logic [4:0] Rs2B;
    logic [4:0] Rs1C;
    logic [4:0] Rs2C;
    logic [4:0] RdC;
    logic       RegWriteC;
    logic [1:0] ResultSrcC;
    logic [4:0] RdD;
    logic       RegWriteD;
    logic [4:0] RdE;
    logic       RegWriteE;
    logic       PCSrcC;
    logic       MulDivC;
    logic [2:0] Funct3C;

    logic       StallA;
    logic       StallB;
    logic       StallC;
    logic       FlushB;
    logic       FlushC;
    logic [1:0] ForwardAC;
    logic [1:0] ForwardBC;
    logic       MulDivDoneC;

    modport master (
        output Rs1B, Rs2B, Rs1C, Rs2C, RdC, RegWriteC,
        output ResultSrcC, RdD, RegWriteD, RdE, RegWriteE,
        output PCSrcC, MulDivC, Funct3C,
        input  StallA, StallB, StallC, FlushB, FlushC,
        input  ForwardAC, ForwardBC, MulDivDoneC
    );

    modport slave (
        input  Rs1B, Rs2B, Rs1C, Rs2C, RdC, RegWriteC,
        input  ResultSrcC, RdD, RegWriteD, RdE, RegWriteE,
        input  PCSrcC, MulDivC, Funct3C,
        output StallA, StallB, StallC, FlushB, FlushC,
        output ForwardAC, ForwardBC, MulDivDoneC
    );

endinterface

// File: rtl/muldiv_seq.sv
// Multi-cycle MUL/DIV occupancy sequencer for the execute stage.
// Instantiated by hazard_ctrl only under HAZARD_MULDIV_EN.
module muldiv_seq
    import hazard_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic muldiv_i,
    input  logic div_i,
    output logic stall_o,
    output logic hold_o,
    output logic done_o
);

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] lat;

    assign lat = div_i ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);

    // State and countdown registers; reset aborts any op in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEQ_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: first cycle stalls in IDLE, the rest count down in BUSY.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall_o = 1'b0;
        hold_o  = 1'b0;
        done_o  = 1'b0;
        unique case (state_q)
            SEQ_IDLE: begin
                if (muldiv_i) begin
                    if (lat > CNT_W'(1)) begin
                        stall_o = 1'b1;
                        state_d = SEQ_BUSY;
                        cnt_d   = lat - CNT_W'(2);
                    end else begin
                        done_o = 1'b1;
                    end
                end
            end
            SEQ_BUSY: begin
                if (cnt_q != '0) begin
                    stall_o = 1'b1;
                    hold_o  = 1'b1;
                    cnt_d   = cnt_q - CNT_W'(1);
                end else begin
                    done_o  = 1'b1;
                    state_d = SEQ_IDLE;
                end
            end
            default: state_d = SEQ_IDLE;
        endcase
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: load-use stall, branch flush, forwarding.
// Define HAZARD_MULDIV_EN to add the multi-cycle MUL/DIV sequencer.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input logic         clk,
    input logic         rst_n,
    hazard_ctrl_if.slave hz
);

    logic load_use;
    logic m_stall;
    logic m_hold;
    logic m_done;

`ifdef HAZARD_MULDIV_EN
    muldiv_seq #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .muldiv_i (hz.MulDivC),
        .div_i    (hz.Funct3C[2]),
        .stall_o  (m_stall),
        .hold_o   (m_hold),
        .done_o   (m_done)
    );
`else
    logic unused_ok;
    assign unused_ok = ^{clk, hz.MulDivC, hz.Funct3C, MUL_LAT, DIV_LAT};
    assign m_stall   = 1'b0;
    assign m_hold    = 1'b0;
    assign m_done    = 1'b0;
`endif

    // Load in execute feeding the decode-stage instruction.
    always_comb begin
        load_use = (hz.ResultSrcC == RES_LOAD) && hz.RegWriteC &&
                   (hz.RdC != 5'd0) &&
                   ((hz.RdC == hz.Rs1B) || (hz.RdC == hz.Rs2B));
    end

    // Output merge; busy sequencer masks flushes, all zero in reset.
    always_comb begin
        hz.StallA      = 1'b0;
        hz.StallB      = 1'b0;
        hz.StallC      = 1'b0;
        hz.FlushB      = 1'b0;
        hz.FlushC      = 1'b0;
        hz.ForwardAC   = FWD_RF;
        hz.ForwardBC   = FWD_RF;
        hz.MulDivDoneC = 1'b0;
        if (rst_n) begin
            hz.StallA = m_stall |
                        (load_use & ~hz.PCSrcC & ~m_hold);
            hz.StallB = hz.StallA;
            hz.StallC = m_stall;
            hz.FlushB = hz.PCSrcC & ~m_hold;
            hz.FlushC = (hz.PCSrcC | load_use) & ~m_hold;
            hz.ForwardAC = fwd_sel(hz.Rs1C, hz.RdD, hz.RegWriteD,
                                   hz.RdE, hz.RegWriteE);
            hz.ForwardBC = fwd_sel(hz.Rs2C, hz.RdD, hz.RegWriteD,
                                   hz.RdE, hz.RegWriteE);
            hz.MulDivDoneC = m_done;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl.
// Sequencer vectors run only when HAZARD_MULDIV_EN is defined.
module tb_hazard_ctrl;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    hazard_ctrl_if hz ();

    hazard_ctrl #(
        .MUL_LAT (3),
        .DIV_LAT (33)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {SA,SB,SC,FB,FC,FwdA[1:0],FwdB[1:0],Done}
    function automatic logic [9:0] outs();
        return {hz.StallA, hz.StallB, hz.StallC, hz.FlushB,
                hz.FlushC, hz.ForwardAC, hz.ForwardBC,
                hz.MulDivDoneC};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        hz.Rs1B = 0; hz.Rs2B = 0; hz.Rs1C = 0; hz.Rs2C = 0;
        hz.RdC = 0; hz.RegWriteC = 0; hz.ResultSrcC = 0;
        hz.RdD = 0; hz.RegWriteD = 0; hz.RdE = 0; hz.RegWriteE = 0;
        hz.PCSrcC = 0; hz.MulDivC = 0; hz.Funct3C = 0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        clr();
        // Every hazard condition active while held in reset.
        hz.ResultSrcC = 2'b01; hz.RegWriteC = 1; hz.RdC = 5;
        hz.Rs1B = 5; hz.PCSrcC = 1;
        hz.RdD = 7; hz.RegWriteD = 1; hz.Rs1C = 7; hz.Rs2C = 7;
        hz.MulDivC = 1;
        #3;
        chk("rst_outs", 32'(outs()), 32'b0);
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clr();
        #1;
        chk("idle_outs", 32'(outs()), 32'b0);

        // Load-use on Rs1B and on Rs2B.
        hz.ResultSrcC = 2'b01; hz.RegWriteC = 1; hz.RdC = 5;
        hz.Rs1B = 5;
        #1 chk("lu_rs1", 32'(outs()), 32'b1100100000);
        hz.Rs1B = 0; hz.Rs2B = 5;
        #1 chk("lu_rs2", 32'(outs()), 32'b1100100000);
        hz.ResultSrcC = 2'b00;
        #1 chk("lu_notload", 32'(outs()), 32'b0);
        hz.ResultSrcC = 2'b01; hz.RegWriteC = 0;
        #1 chk("lu_nowrite", 32'(outs()), 32'b0);
        hz.RegWriteC = 1; hz.RdC = 0; hz.Rs1B = 0; hz.Rs2B = 0;
        #1 chk("lu_x0", 32'(outs()), 32'b0);

        // Branch overrides load-use.
        hz.RdC = 5; hz.Rs1B = 5; hz.PCSrcC = 1;
        #1 chk("pc_over_lu", 32'(outs()), 32'b0001100000);
        clr(); hz.PCSrcC = 1;
        #1 chk("pc_only", 32'(outs()), 32'b0001100000);
        clr();

        // Forwarding priority.
        hz.RdD = 7; hz.RdE = 7; hz.RegWriteD = 1; hz.RegWriteE = 1;
        hz.Rs1C = 7; hz.Rs2C = 7;
        #1 chk("fwd_mem", 32'(outs()), 32'b0000001010);
        hz.RegWriteD = 0;
        #1 chk("fwd_wb", 32'(outs()), 32'b0000010100);
        hz.RegWriteD = 1; hz.RdD = 0; hz.RdE = 0;
        hz.Rs1C = 0; hz.Rs2C = 0;
        #1 chk("fwd_x0", 32'(outs()), 32'b0);
        hz.RdD = 7; hz.RdE = 3; hz.Rs1C = 7; hz.Rs2C = 3;
        #1 chk("fwd_mix", 32'(outs()), 32'b0000001100);
        hz.Rs1C = 3; hz.Rs2C = 9;
        #1 chk("fwd_mix2", 32'(outs()), 32'b0000010000);
        clr();

`ifdef HAZARD_MULDIV_EN
        begin
            int ns;
            int done_at;
            int dn;
            // MUL: two stall cycles, done in the third.
            @(posedge clk); #1;
            hz.MulDivC = 1; hz.Funct3C = 3'b000;
            @(negedge clk);
            chk("mul_c1", 32'(outs()), 32'b1110000000);
            @(posedge clk); #1;
            hz.MulDivC = 0; hz.Funct3C = 3'b100;
            hz.PCSrcC = 1;
            hz.ResultSrcC = 2'b01; hz.RegWriteC = 1;
            hz.RdC = 5; hz.Rs1B = 5;
            @(negedge clk);
            chk("mul_c2_hold", 32'(outs()), 32'b1110000000);
            @(posedge clk); #1;
            clr();
            @(negedge clk);
            chk("mul_c3_done", 32'(outs()), 32'b0000000001);
            @(posedge clk); #1;
            @(negedge clk);
            chk("mul_after", 32'(outs()), 32'b0);

            // DIV: 32 stall cycles, done in cycle 33.
            @(posedge clk); #1;
            hz.MulDivC = 1; hz.Funct3C = 3'b100;
            ns = 0; done_at = 0;
            for (int i = 1; i <= 100; i++) begin
                @(negedge clk);
                if (hz.MulDivDoneC) begin
                    done_at = i;
                    chk("div_done_outs", 32'(outs()), 32'b1);
                    break;
                end
                if (hz.StallC) ns++;
                @(posedge clk); #1;
                hz.MulDivC = 0; hz.Funct3C = 3'b000;
            end
            chk("div_stalls", 32'(ns), 32'd32);
            chk("div_done_cyc", 32'(done_at), 32'd33);

            // Reset pulse at the 10th DIV stall cycle.
            @(posedge clk); #1;
            hz.MulDivC = 1; hz.Funct3C = 3'b100;
            ns = 0;
            for (int i = 1; i <= 20 && ns < 10; i++) begin
                @(negedge clk);
                if (hz.StallC) ns++;
                if (ns < 10) begin
                    @(posedge clk); #1;
                    hz.MulDivC = 0; hz.Funct3C = 3'b000;
                end
            end
            chk("abort_reach10", 32'(ns), 32'd10);
            #1 rst_n = 1'b0;
            #1 chk("abort_async", 32'(outs()), 32'b0);
            hz.MulDivC = 0;
            @(posedge clk); @(posedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            chk("abort_idle", 32'(outs()), 32'b0);
            dn = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (hz.MulDivDoneC || hz.StallC) dn++;
            end
            chk("abort_no_done", 32'(dn), 32'd0);
        end
`else
        begin
            int bad;
            bad = 0;
            hz.MulDivC = 1; hz.Funct3C = 3'b000;
            for (int i = 0; i < 40; i++) begin
                if (i == 20) hz.Funct3C = 3'b100;
                @(negedge clk);
                if (hz.StallC || hz.MulDivDoneC ||
                    hz.StallA) bad++;
            end
            chk("nomd_quiet", 32'(bad), 32'd0);
            chk("nomd_outs", 32'(outs()), 32'b0);
            clr();
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
